// File: rtl/mc_control_unit.sv
// ============================================================================
// mc_control_unit
// ----------------------------------------------------------------------------
// Purpose:
//   Control FSM for a multicycle RV32 datapath with one shared memory port.
//   The datapath holds PC, IR, OldPC, Data and ALUOut registers. This unit
//   sequences them and handles a req/ready memory handshake with wait states.
//   A wait that never completes ends in a timeout. An illegal opcode, an
//   illegal funct3 or a memory timeout halts the FSM in a sticky TRAP state
//   that only reset can leave.
//
// Parameters:
//   MEM_TIMEOUT - maximum consecutive non-ready cycles in a memory state
//                 (0 = wait forever)
//   STATE_W     - width of the state_o debug port
//
// Ports:
//   clk, rst      - clock (rising edge); asynchronous active-high reset
//   op            - IR[6:0]
//   funct3        - IR[14:12]
//   funct7b5      - IR[30]
//   zero          - ALU zero flag
//   mem_ready     - memory completes the current access this cycle
//   mem_req       - memory access request (FETCH / MEMREAD / MEMWRITE)
//   PCWrite       - PC <= Result
//   AdrSrc        - memory address select: 0 = PC, 1 = Result
//   MemWrite      - memory write strobe
//   IRWrite       - IR <= RD, OldPC <= PC
//   RegWrite      - register file write rd <= Result
//   ResultSrc     - 00 = ALUOut, 01 = Data, 10 = ALUResult
//   ALUSrcA       - 00 = PC, 01 = OldPC, 10 = rs1
//   ALUSrcB       - 00 = rs2, 01 = ImmExt, 10 = constant 4
//   ImmSrc        - 00 = I, 01 = S, 10 = B, 11 = J (decoded from op in every state)
//   ALUControl    - 000 add, 001 sub, 010 and, 011 or, 101 slt
//   trap          - sticky halt indicator
//   trap_cause    - 00 none, 01 illegal op, 10 illegal funct3, 11 memory timeout
//   state_o       - current state encoding (debug)
// ============================================================================
module mc_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int STATE_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic [2:0]         ALUControl,
    output logic               trap,
    output logic [1:0]         trap_cause,
    output logic [STATE_W-1:0] state_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_LW   = 7'd3;
    localparam logic [6:0] OP_SW   = 7'd35;
    localparam logic [6:0] OP_R    = 7'd51;
    localparam logic [6:0] OP_I    = 7'd19;
    localparam logic [6:0] OP_BEQ  = 7'd99;
    localparam logic [6:0] OP_JAL  = 7'd111;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_OP      = 2'b01;
    localparam logic [1:0] CAUSE_FUNCT3  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    // The wait counter must hold 0..MEM_TIMEOUT-1 and is never narrower
    // than one bit, even when the timeout is disabled.
    localparam int CNT_W_RAW = $clog2(MEM_TIMEOUT + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam int TO_M1     = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = TO_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [CNT_W-1:0] r_wait;
    logic             r_trap;
    logic [1:0]       r_cause;

    logic w_in_mem;
    logic w_timeout;
    logic w_wait_sat;
    logic w_f3_ok;

    assign w_in_mem   = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                        (r_state == S_MEMWRITE);
    // Reaching TO_LAST with ready still low completes the MEM_TIMEOUT-th
    // idle cycle. A ready in that same cycle wins because the timeout is
    // evaluated only when mem_ready is low.
    assign w_timeout  = (MEM_TIMEOUT > 0) && !mem_ready && (r_wait == TO_LAST);
    assign w_wait_sat = &r_wait;
    assign w_f3_ok    = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                        (funct3 == 3'b110) || (funct3 == 3'b111);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_trap  <= 1'b0;
            r_cause <= CAUSE_NONE;
        end else if (w_in_mem && !mem_ready) begin
            // Wait state: either time out or keep counting. The counter
            // saturates so that it cannot wrap when the timeout is disabled.
            if (w_timeout) begin
                r_state <= S_TRAP;
                r_trap  <= 1'b1;
                r_cause <= CAUSE_TIMEOUT;
                r_wait  <= '0;
            end else if (!w_wait_sat) begin
                r_wait <= r_wait + CNT_ONE;
            end
        end else begin
            // Every other case is a transition or a single-cycle state.
            // Clearing the counter here means each memory state is entered
            // with a zero count.
            r_wait <= '0;
            case (r_state)
                S_FETCH:    r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_R:         r_state <= S_EXECR;
                        OP_I:         r_state <= S_EXECI;
                        OP_BEQ:       r_state <= S_BEQ;
                        OP_JAL:       r_state <= S_JAL;
                        default: begin
                            r_state <= S_TRAP;
                            r_trap  <= 1'b1;
                            r_cause <= CAUSE_OP;
                        end
                    endcase
                end
                S_MEMADR:   r_state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: r_state <= S_FETCH;
                S_EXECR, S_EXECI: begin
                    if (w_f3_ok) begin
                        r_state <= S_ALUWB;
                    end else begin
                        r_state <= S_TRAP;
                        r_trap  <= 1'b1;
                        r_cause <= CAUSE_FUNCT3;
                    end
                end
                S_ALUWB:    r_state <= S_FETCH;
                S_BEQ:      r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_TRAP:     r_state <= S_TRAP;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (combinational from state plus mem_ready / zero)
    // ------------------------------------------------------------------
    logic       w_mem_req;
    logic       w_pcwrite;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic [1:0] w_alu_op;

    always_comb begin
        w_mem_req  = 1'b0;
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        w_alu_op   = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                AdrSrc    = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
            end
            S_MEMWRITE: begin
                w_mem_req  = 1'b1;
                AdrSrc     = 1'b1;
                w_memwrite = mem_ready;
            end
            S_EXECR: begin
                ALUSrcA  = 2'b10;
                w_alu_op = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA  = 2'b10;
                ALUSrcB  = 2'b01;
                w_alu_op = 2'b10;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = 2'b10;
                w_alu_op  = 2'b01;
                w_pcwrite = zero;
            end
            S_JAL: begin
                // ALUOut already holds the jump target from DECODE. PC takes
                // it while the ALU forms OldPC+4 for the link write in ALUWB.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        ALUControl = 3'b000;
        case (w_alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    // op[5] separates R-type from I-type, so addi never subtracts.
                    3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Reset masks every strobe directly. This prevents a partial write or
    // fetch while rst is high, even in the cycle where it is asserted.
    assign mem_req    = w_mem_req  & ~rst;
    assign PCWrite    = w_pcwrite  & ~rst;
    assign MemWrite   = w_memwrite & ~rst;
    assign IRWrite    = w_irwrite  & ~rst;
    assign RegWrite   = w_regwrite & ~rst;
    assign trap       = r_trap;
    assign trap_cause = r_cause;
    assign state_o    = STATE_W'(r_state);

endmodule

// File: tb/tb_mc_control_unit.sv
// ============================================================================
// tb_mc_control_unit
// ----------------------------------------------------------------------------
// Directed bench for mc_control_unit, built with MEM_TIMEOUT = 4. Each
// instruction is walked cycle by cycle. The bench checks the state number
// and the packed strobes {mem_req, PCWrite, IRWrite, MemWrite, RegWrite}
// against hand-computed values. It also checks the ALU control, trap status
// and trap cause where they matter.
// ============================================================================
`timescale 1ns/1ps
module tb_mc_control_unit;

    localparam int TO = 4;

    // State encodings as seen on state_o
    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2,
                           MEMREAD = 4'd3, MEMWB = 4'd4, MEMWRITE = 4'd5,
                           EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8,
                           BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd11;
    // Strobe patterns {mem_req, PCWrite, IRWrite, MemWrite, RegWrite}
    localparam logic [4:0] SB_NONE  = 5'b00000;
    localparam logic [4:0] SB_FETCH = 5'b11100;
    localparam logic [4:0] SB_REQ   = 5'b10000;
    localparam logic [4:0] SB_MEMW  = 5'b10010;
    localparam logic [4:0] SB_RW    = 5'b00001;
    localparam logic [4:0] SB_PC    = 5'b01000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, trap;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, trap_cause;
    logic [2:0] ALUControl;
    logic [3:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    mc_control_unit #(.MEM_TIMEOUT(TO), .STATE_W(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .trap(trap), .trap_cause(trap_cause),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {mem_req, PCWrite, IRWrite, MemWrite, RegWrite};
    endfunction

    // Check the current cycle (inputs already applied) and advance one clock.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [4:0] sb);
        #1;
        chk({tag, ".state"}, 8'(state_o), 8'(st));
        chk({tag, ".strb"}, 8'(strobes()), 8'(sb));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk({tag, ".rst_state"}, 8'(state_o), 8'(FETCH));
        chk({tag, ".rst_strb"}, 8'(strobes()), 8'(SB_NONE));
        chk({tag, ".rst_trap"}, 8'(trap), 8'd0);
        chk({tag, ".rst_cause"}, 8'(trap_cause), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // Reset: strobes stay masked even though mem_ready is high in FETCH.
        @(posedge clk);
        #1;
        do_reset("reset");

        // lw with memory always ready
        op = 7'd3; mem_ready = 1'b1;
        cyc("lw.fetch", FETCH, SB_FETCH);
        cyc("lw.decode", DECODE, SB_NONE);
        cyc("lw.memadr", MEMADR, SB_NONE);
        cyc("lw.memread", MEMREAD, SB_REQ);
        cyc("lw.memwb", MEMWB, SB_RW);

        // add
        op = 7'd51; funct3 = 3'b000; funct7b5 = 1'b0;
        cyc("add.fetch", FETCH, SB_FETCH);
        cyc("add.decode", DECODE, SB_NONE);
        #1 chk("add.aluctl", 8'(ALUControl), 8'h0);
        cyc("add.execr", EXECR, SB_NONE);
        cyc("add.aluwb", ALUWB, SB_RW);

        // sub
        funct7b5 = 1'b1;
        cyc("sub.fetch", FETCH, SB_FETCH);
        cyc("sub.decode", DECODE, SB_NONE);
        #1 chk("sub.aluctl", 8'(ALUControl), 8'h1);
        cyc("sub.execr", EXECR, SB_NONE);
        cyc("sub.aluwb", ALUWB, SB_RW);

        // addi with IR[30] set must still add; then or, slt via R-type
        op = 7'd19; funct3 = 3'b000; funct7b5 = 1'b1;
        cyc("addi.fetch", FETCH, SB_FETCH);
        cyc("addi.decode", DECODE, SB_NONE);
        #1 chk("addi.aluctl", 8'(ALUControl), 8'h0);
        cyc("addi.execi", EXECI, SB_NONE);
        cyc("addi.aluwb", ALUWB, SB_RW);

        op = 7'd51; funct3 = 3'b110; funct7b5 = 1'b0;
        cyc("or.fetch", FETCH, SB_FETCH);
        cyc("or.decode", DECODE, SB_NONE);
        #1 chk("or.aluctl", 8'(ALUControl), 8'h3);
        cyc("or.execr", EXECR, SB_NONE);
        cyc("or.aluwb", ALUWB, SB_RW);

        op = 7'd19; funct3 = 3'b010;
        cyc("slti.fetch", FETCH, SB_FETCH);
        cyc("slti.decode", DECODE, SB_NONE);
        #1 chk("slti.aluctl", 8'(ALUControl), 8'h5);
        cyc("slti.execi", EXECI, SB_NONE);
        cyc("slti.aluwb", ALUWB, SB_RW);

        // beq taken / not taken
        op = 7'd99; funct3 = 3'b000; zero = 1'b1;
        cyc("beq1.fetch", FETCH, SB_FETCH);
        #1 chk("beq1.immsrc", 8'(ImmSrc), 8'h2);
        cyc("beq1.decode", DECODE, SB_NONE);
        #1 chk("beq1.aluctl", 8'(ALUControl), 8'h1);
        cyc("beq1.beq", BEQ, SB_PC);
        zero = 1'b0;
        cyc("beq0.fetch", FETCH, SB_FETCH);
        cyc("beq0.decode", DECODE, SB_NONE);
        cyc("beq0.beq", BEQ, SB_NONE);

        // jal
        op = 7'd111;
        cyc("jal.fetch", FETCH, SB_FETCH);
        cyc("jal.decode", DECODE, SB_NONE);
        cyc("jal.jal", JAL, SB_PC);
        cyc("jal.aluwb", ALUWB, SB_RW);

        // sw with two wait cycles in MEMWRITE
        op = 7'd35; funct3 = 3'b010;
        cyc("sw.fetch", FETCH, SB_FETCH);
        cyc("sw.decode", DECODE, SB_NONE);
        cyc("sw.memadr", MEMADR, SB_NONE);
        mem_ready = 1'b0;
        cyc("sw.wait1", MEMWRITE, SB_REQ);
        cyc("sw.wait2", MEMWRITE, SB_REQ);
        mem_ready = 1'b1;
        cyc("sw.ready", MEMWRITE, SB_MEMW);

        // Ready on the MEM_TIMEOUT-th FETCH cycle is accepted normally
        op = 7'd51; funct3 = 3'b111; funct7b5 = 1'b0;
        mem_ready = 1'b0;
        for (int i = 0; i < TO - 1; i++) cyc($sformatf("late.wait%0d", i), FETCH, SB_REQ);
        mem_ready = 1'b1;
        cyc("late.fetch", FETCH, SB_FETCH);
        cyc("late.decode", DECODE, SB_NONE);
        #1 chk("and.aluctl", 8'(ALUControl), 8'h2);
        cyc("late.execr", EXECR, SB_NONE);
        cyc("late.aluwb", ALUWB, SB_RW);

        // Illegal funct3 traps from EXECR with no register write
        funct3 = 3'b001;
        cyc("f3.fetch", FETCH, SB_FETCH);
        cyc("f3.decode", DECODE, SB_NONE);
        cyc("f3.execr", EXECR, SB_NONE);
        cyc("f3.trap", TRAP, SB_NONE);
        chk("f3.trapflag", 8'(trap), 8'd1);
        chk("f3.cause", 8'(trap_cause), 8'h2);
        do_reset("f3");

        // Illegal opcode traps from DECODE
        op = 7'h7F; funct3 = 3'b000;
        cyc("ill.fetch", FETCH, SB_FETCH);
        cyc("ill.decode", DECODE, SB_NONE);
        cyc("ill.trap", TRAP, SB_NONE);
        chk("ill.cause", 8'(trap_cause), 8'h1);
        cyc("ill.hold", TRAP, SB_NONE);
        do_reset("ill");

        // Fetch timeout after MEM_TIMEOUT idle cycles
        op = 7'd3; mem_ready = 1'b0;
        for (int i = 0; i < TO; i++) cyc($sformatf("to.wait%0d", i), FETCH, SB_REQ);
        mem_ready = 1'b1;
        cyc("to.trap", TRAP, SB_NONE);
        chk("to.trapflag", 8'(trap), 8'd1);
        chk("to.cause", 8'(trap_cause), 8'h3);
        do_reset("to");

        // Asynchronous reset in the middle of MEMREAD
        op = 7'd3; mem_ready = 1'b1;
        cyc("ar.fetch", FETCH, SB_FETCH);
        cyc("ar.decode", DECODE, SB_NONE);
        cyc("ar.memadr", MEMADR, SB_NONE);
        mem_ready = 1'b0;
        #1 chk("ar.memread", 8'(state_o), 8'(MEMREAD));
        #1 rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        chk("ar.state", 8'(state_o), 8'(FETCH));
        chk("ar.strb", 8'(strobes()), 8'(SB_NONE));
        chk("ar.trap", 8'(trap), 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        cyc("ar.refetch", FETCH, SB_FETCH);
        cyc("ar.redecode", DECODE, SB_NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
